eeg_epoch_loader: RTL and testbench
===================================

Name: eeg_epoch_loader

Overview:
Parametrised multi-channel EEG ingest front end between the SoC control interface and the centralized CIM core's intermediate-result memory write port. Interleaved ADC samples are buffered in a FIFO, converted to the core's fixed-point width and written channel-major under memory backpressure. Once a full epoch is stored it launches inference and returns the latched sleep stage to the SoC. Successor to the single-channel, fixed-width SoC control path; adds channel count, depth, format conversion, backpressure and error reporting.

Parameters:
NUM_CHANNELS, 1, EEG channels interleaved on eeg (ch0, ch1, ... repeating)
SAMPLES_PER_EPOCH, 3000, samples per channel per epoch
ADC_W, 16, ADC sample width
DATA_W, 22, memory data width; must satisfy DATA_W >= ADC_W + SHIFT
SHIFT, 0, left shift applied after sign extension (fractional alignment)
OFFSET_BINARY, 1, 1: ADC is offset-binary (MSB inverted to obtain two's complement); 0: already two's complement
FIFO_DEPTH, 8, buffer entries; power of two, >= 2
ADDR_W, 16, memory address width
BASE_ADDR, 0, address of ch0 sample 0

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
start_eeg_load  in  1  pulse: begin (or restart) epoch load
new_eeg_data  in  1  pulse: eeg valid this cycle
eeg  in  ADC_W  ADC sample
new_sleep_epoch  in  1  pulse: SoC epoch boundary
mem_wr_en  out  1  write request valid
mem_wr_addr  out  ADDR_W  write address
mem_wr_data  out  DATA_W  converted sample
mem_wr_ready  in  1  memory accepts the write this cycle
start_inference  out  1  one-cycle pulse to the core
core_inference_complete  in  1  pulse from the core
core_sleep_stage  in  3  stage, valid with core_inference_complete
inference_complete  out  1  one-cycle pulse to the SoC
inferred_sleep_stage  out  3  last inferred stage, held
busy  out  1  state != IDLE
overflow  out  1  sticky: sample dropped on full FIFO
short_epoch  out  1  sticky: epoch ended before load completed

Behaviour:
- Reset (async): state IDLE; FIFO empty; counters 0. All outputs 0: mem_wr_en, mem_wr_addr, mem_wr_data, start_inference, inference_complete, inferred_sleep_stage, busy, overflow, short_epoch.
- States: IDLE -> LOAD on start_eeg_load. LOAD -> LAUNCH when the final write (NUM_CHANNELS*SAMPLES_PER_EPOCH) handshakes. LAUNCH asserts start_inference for exactly 1 cycle -> INFER. INFER -> IDLE on core_inference_complete; same edge: latch core_sleep_stage into inferred_sleep_stage and pulse inference_complete for 1 cycle.
- start_eeg_load in any state: flush FIFO, clear counters, overflow and short_epoch; enter LOAD next cycle. If in INFER, a later core_inference_complete is ignored (no pulse, stage not updated).
- Push: new_eeg_data in LOAD while accepted count < total. Samples beyond the total are ignored. Samples in other states are ignored.
- Full FIFO: push accepted only if a pop occurs the same cycle; otherwise the sample is dropped and overflow is set. The accepted count does not advance on a drop.
- Conversion at push: invert MSB if OFFSET_BINARY, sign-extend to DATA_W, then shift left by SHIFT.
- Write side: mem_wr_en = FIFO non-empty; mem_wr_data = FIFO head.
  - mem_wr_addr = BASE_ADDR + ch*SAMPLES_PER_EPOCH + idx.
  - ch wraps at NUM_CHANNELS; idx increments on each ch wrap.
  - Pop and counter advance only when mem_wr_en && mem_wr_ready.
  - Address, data and en stay stable while ready is low.
- Latency: a sample pushed at edge N is visible on mem_wr_* after edge N (registered FIFO, no bypass).
- new_sleep_epoch in LOAD before the final write: set short_epoch, flush, go to IDLE. Ignored in other states.
- Simultaneous start_eeg_load and new_sleep_epoch: start_eeg_load wins and short_epoch is not set.

Test Plan:
- NUM_CHANNELS=2, SAMPLES_PER_EPOCH=4, BASE_ADDR=0x100, ready=1, 8 samples s0..s7 -> addresses 0x100,0x104,0x101,0x105,0x102,0x106,0x103,0x107 in order. start_inference pulses once, 1 cycle after the 8th write.
- OFFSET_BINARY=1, ADC_W=16, DATA_W=22, SHIFT=2: eeg 0x8000 -> data 0x000000; 0xFFFF -> 0x01FFFC; 0x0000 -> 0x3E0000.
- FIFO_DEPTH=4, mem_wr_ready=0, 5 samples pushed -> overflow=1 after the 5th. Releasing ready then yields exactly 4 writes with addresses/data stable during the stall.
- In INFER, core_inference_complete with stage 3 -> inference_complete high exactly 1 cycle, inferred_sleep_stage=3 held, busy=0 next cycle.
- new_sleep_epoch after 5 of 8 writes -> short_epoch=1, IDLE, no start_inference. Subsequent start_eeg_load clears short_epoch and restarts at BASE_ADDR.
- rst_n low mid-LOAD with the FIFO holding 3 entries -> all outputs 0 immediately (asynchronously). After release, mem_wr_en stays 0 until new samples are pushed.

Source files
------------

// File: rtl/eeg_epoch_loader_if.sv
// eeg_epoch_loader_if: SoC control, ADC ingest, CIM write port and core handshake bundle
interface eeg_epoch_loader_if #(
   parameter int ADC_W  = 16,
   parameter int DATA_W = 22,
   parameter int ADDR_W = 16
);
   logic              start_eeg_load;
   logic              new_eeg_data;
   logic [ADC_W-1:0]  eeg;
   logic              new_sleep_epoch;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic              mem_wr_ready;
   logic              start_inference;
   logic              core_inference_complete;
   logic [2:0]        core_sleep_stage;
   logic              inference_complete;
   logic [2:0]        inferred_sleep_stage;
   logic              busy;
   logic              overflow;
   logic              short_epoch;

   modport master (
      output start_eeg_load, new_eeg_data, eeg, new_sleep_epoch, mem_wr_ready,
             core_inference_complete, core_sleep_stage,
      input  mem_wr_en, mem_wr_addr, mem_wr_data, start_inference, inference_complete,
             inferred_sleep_stage, busy, overflow, short_epoch
   );

   modport slave (
      input  start_eeg_load, new_eeg_data, eeg, new_sleep_epoch, mem_wr_ready,
             core_inference_complete, core_sleep_stage,
      output mem_wr_en, mem_wr_addr, mem_wr_data, start_inference, inference_complete,
             inferred_sleep_stage, busy, overflow, short_epoch
   );
endinterface

// File: rtl/eeg_epoch_loader.sv
// eeg_epoch_loader: buffers interleaved EEG samples, writes them channel-major to CIM memory, launches inference
module eeg_epoch_loader #(
   parameter int NUM_CHANNELS      = 1,
   parameter int SAMPLES_PER_EPOCH = 3000,
   parameter int ADC_W             = 16,
   parameter int DATA_W            = 22,
   parameter int SHIFT             = 0,
   parameter int OFFSET_BINARY     = 1,
   parameter int FIFO_DEPTH        = 8,
   parameter int ADDR_W            = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input logic clk,
   input logic rst_n,
   eeg_epoch_loader_if.slave bus
);
   localparam int TOTAL = NUM_CHANNELS * SAMPLES_PER_EPOCH;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CH_W  = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
   localparam logic OB  = (OFFSET_BINARY != 0);
   localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, LAUNCH = 2'd2, INFER = 2'd3;

   logic [1:0]        state;
   logic [DATA_W-1:0] fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]  wp, rp;
   logic [PTR_W:0]    count;
   logic [CNT_W-1:0]  acc_cnt, wr_cnt;
   logic [CH_W-1:0]   ch;
   logic [ADDR_W-1:0] ch_off, idx;
   logic [ADC_W-1:0]  adc_tc;
   logic [DATA_W-1:0] conv;
   logic nonempty, full, pop, last_wr, abort, flush, push_req, push, done, ch_last;

   assign nonempty = count != '0;
   assign full     = count == (PTR_W+1)'(FIFO_DEPTH);
   assign pop      = nonempty && bus.mem_wr_ready;
   assign last_wr  = state == LOAD && pop && wr_cnt == CNT_W'(TOTAL - 1);
   // the final write completing wins over a coincident epoch boundary
   assign abort    = state == LOAD && bus.new_sleep_epoch && !bus.start_eeg_load && !last_wr;
   assign flush    = bus.start_eeg_load || abort;
   assign push_req = state == LOAD && bus.new_eeg_data && acc_cnt < CNT_W'(TOTAL) && !flush;
   assign push     = push_req && (!full || pop);
   assign done     = state == INFER && bus.core_inference_complete && !bus.start_eeg_load;
   assign ch_last  = ch == CH_W'(NUM_CHANNELS - 1);
   assign adc_tc   = {bus.eeg[ADC_W-1] ^ OB, bus.eeg[ADC_W-2:0]};
   assign conv     = DATA_W'($signed(adc_tc)) << SHIFT;

   assign bus.mem_wr_en       = nonempty;
   assign bus.mem_wr_data     = nonempty ? fifo[rp] : '0;
   assign bus.mem_wr_addr     = nonempty ? BASE_ADDR + ch_off + idx : '0;
   assign bus.start_inference = state == LAUNCH;
   assign bus.busy            = state != IDLE;

   // control FSM: restart from any state, abort on early epoch boundary
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= bus.start_eeg_load ? LOAD :
                    state == LOAD   ? (last_wr ? LAUNCH : abort ? IDLE : LOAD) :
                    state == LAUNCH ? INFER :
                    done            ? IDLE : state;

   // FIFO storage holds already-converted samples
   always_ff @(posedge clk)
      if (push) fifo[wp] <= conv;

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (flush) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + PTR_W'(1);
         if (pop) rp <= rp + PTR_W'(1);
         count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end

   // accepted-sample count and channel-major write address walk
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc_cnt <= '0;
         wr_cnt  <= '0;
         ch      <= '0;
         ch_off  <= '0;
         idx     <= '0;
      end else if (flush) begin
         acc_cnt <= '0;
         wr_cnt  <= '0;
         ch      <= '0;
         ch_off  <= '0;
         idx     <= '0;
      end else begin
         if (push) acc_cnt <= acc_cnt + CNT_W'(1);
         if (pop) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
            ch     <= ch_last ? '0 : ch + CH_W'(1);
            ch_off <= ch_last ? '0 : ch_off + ADDR_W'(SAMPLES_PER_EPOCH);
            idx    <= ch_last ? idx + ADDR_W'(1) : idx;
         end
      end

   // sticky error flags, completion pulse and latched sleep stage
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.overflow             <= 1'b0;
         bus.short_epoch          <= 1'b0;
         bus.inference_complete   <= 1'b0;
         bus.inferred_sleep_stage <= 3'd0;
      end else begin
         bus.overflow           <= !bus.start_eeg_load && (bus.overflow || (push_req && full && !pop));
         bus.short_epoch        <= !bus.start_eeg_load && (bus.short_epoch || abort);
         bus.inference_complete <= done;
         if (done) bus.inferred_sleep_stage <= bus.core_sleep_stage;
      end
endmodule

// File: tb/tb_eeg_epoch_loader.sv
// tb_eeg_epoch_loader: randomized scenarios checked against an arithmetic address/conversion model
module tb_eeg_epoch_loader;
   localparam int NC = 2, SPE = 4, ADC_W = 16, DATA_W = 22, SHIFT = 2, FD = 4, ADDR_W = 16, BASE = 'h100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0, failures = 0, cyc = 0;
   int obs_addr[$], obs_data[$], obs_cyc[$], si_cyc[$];

   eeg_epoch_loader_if #(.ADC_W(ADC_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   eeg_epoch_loader #(
      .NUM_CHANNELS(NC), .SAMPLES_PER_EPOCH(SPE), .ADC_W(ADC_W), .DATA_W(DATA_W), .SHIFT(SHIFT),
      .OFFSET_BINARY(1), .FIFO_DEPTH(FD), .ADDR_W(ADDR_W), .BASE_ADDR(16'h100)
   ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // k-th sample of the interleaved stream belongs to channel k%NC, time index k/NC
   function automatic int exp_addr(int k);
      return BASE + (k % NC) * SPE + k / NC;
   endfunction

   // offset-binary code minus midscale, scaled by 2^SHIFT, wrapped to DATA_W bits
   function automatic int exp_data(int s);
      return ((s - 32768) * (1 << SHIFT)) & ((1 << DATA_W) - 1);
   endfunction

   function automatic logic [46:0] all_outs();
      return {bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, bus.start_inference, bus.inference_complete,
              bus.inferred_sleep_stage, bus.busy, bus.overflow, bus.short_epoch};
   endfunction

   task automatic tick();
      @(negedge clk);
      if (bus.mem_wr_en && bus.mem_wr_ready) begin
         obs_addr.push_back(int'(bus.mem_wr_addr));
         obs_data.push_back(int'(bus.mem_wr_data));
         obs_cyc.push_back(cyc);
      end
      if (bus.start_inference) si_cyc.push_back(cyc);
      @(posedge clk);
      #1 cyc++;
   endtask

   task automatic clear_obs();
      obs_addr.delete();
      obs_data.delete();
      obs_cyc.delete();
      si_cyc.delete();
   endtask

   task automatic pulse_start();
      bus.start_eeg_load = 1'b1;
      tick();
      bus.start_eeg_load = 1'b0;
   endtask

   task automatic push(input int s);
      bus.eeg = 16'(s);
      bus.new_eeg_data = 1'b1;
      tick();
      bus.new_eeg_data = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      checks++;
      if (all_outs() !== '0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", all_outs()); end
      #3 rst_n = 1'b1;
      tick();
      checks++;
      if (all_outs() !== '0) begin failures++; $display("FAIL reset_release_outputs: got %h expected 0", all_outs()); end
   endtask

   task automatic test_main();
      int s[8];
      foreach (s[i]) s[i] = int'($urandom_range(0, 65535));
      s[0] = 'h8000;
      s[1] = 'hFFFF;
      s[2] = 0;
      bus.mem_wr_ready = 1'b1;
      clear_obs();
      pulse_start();
      foreach (s[i]) push(s[i]);
      repeat (4) tick();
      checks++;
      if (obs_addr.size() != 8) begin failures++; $display("FAIL main_write_count: got %0d expected 8", obs_addr.size()); end
      for (int i = 0; i < obs_addr.size() && i < 8; i++) begin
         checks += 2;
         if (obs_addr[i] != exp_addr(i)) begin failures++; $display("FAIL main_addr[%0d]: got %h expected %h", i, obs_addr[i], exp_addr(i)); end
         if (obs_data[i] != exp_data(s[i])) begin failures++; $display("FAIL main_data[%0d]: got %h expected %h (eeg %h)", i, obs_data[i], exp_data(s[i]), s[i]); end
      end
      checks++;
      if (si_cyc.size() != 1 || obs_cyc.size() != 8 || si_cyc[0] != obs_cyc[7] + 1) begin
         failures++;
         $display("FAIL main_start_inference: got %0d pulses first at cycle %0d expected 1 pulse at cycle %0d",
                  si_cyc.size(), si_cyc.size() > 0 ? si_cyc[0] : -1, obs_cyc.size() == 8 ? obs_cyc[7] + 1 : -1);
      end
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL main_busy_infer: got %b expected 1", bus.busy); end
   endtask

   task automatic test_inference();
      bus.core_sleep_stage = 3'd3;
      bus.core_inference_complete = 1'b1;
      tick();
      bus.core_inference_complete = 1'b0;
      bus.core_sleep_stage = 3'($urandom_range(0, 7));
      checks += 3;
      if (bus.inference_complete !== 1'b1) begin failures++; $display("FAIL infer_pulse: got %b expected 1", bus.inference_complete); end
      if (bus.inferred_sleep_stage !== 3'd3) begin failures++; $display("FAIL infer_stage: got %0d expected 3", bus.inferred_sleep_stage); end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL infer_idle: got busy %b expected 0", bus.busy); end
      tick();
      checks += 2;
      if (bus.inference_complete !== 1'b0) begin failures++; $display("FAIL infer_pulse_width: got %b expected 0", bus.inference_complete); end
      if (bus.inferred_sleep_stage !== 3'd3) begin failures++; $display("FAIL infer_stage_hold: got %0d expected 3", bus.inferred_sleep_stage); end
   endtask

   task automatic test_overflow();
      int s[5];
      foreach (s[i]) s[i] = int'($urandom_range(0, 65535));
      bus.mem_wr_ready = 1'b0;
      clear_obs();
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         push(s[i]);
         if (i >= 3) begin
            checks++;
            if (bus.overflow !== (i == 4)) begin failures++; $display("FAIL overflow_after_push%0d: got %b expected %b", i + 1, bus.overflow, i == 4); end
         end
      end
      repeat (3) begin
         tick();
         checks++;
         if ({bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data} !== {1'b1, 16'(exp_addr(0)), 22'(exp_data(s[0]))}) begin
            failures++;
            $display("FAIL stall_hold: got en %b addr %h data %h expected en 1 addr %h data %h",
                     bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, exp_addr(0), exp_data(s[0]));
         end
      end
      bus.mem_wr_ready = 1'b1;
      repeat (8) tick();
      checks++;
      if (obs_addr.size() != 4) begin failures++; $display("FAIL overflow_write_count: got %0d expected 4", obs_addr.size()); end
      for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
         checks += 2;
         if (obs_addr[i] != exp_addr(i)) begin failures++; $display("FAIL overflow_addr[%0d]: got %h expected %h", i, obs_addr[i], exp_addr(i)); end
         if (obs_data[i] != exp_data(s[i])) begin failures++; $display("FAIL overflow_data[%0d]: got %h expected %h", i, obs_data[i], exp_data(s[i])); end
      end
      checks++;
      if (bus.overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky: got %b expected 1", bus.overflow); end
   endtask

   task automatic test_short_epoch();
      int s;
      bus.mem_wr_ready = 1'b1;
      clear_obs();
      pulse_start();
      repeat (5) push(int'($urandom_range(0, 65535)));
      tick();
      checks++;
      if (obs_addr.size() != 5) begin failures++; $display("FAIL short_prewrites: got %0d expected 5", obs_addr.size()); end
      bus.new_sleep_epoch = 1'b1;
      tick();
      bus.new_sleep_epoch = 1'b0;
      checks += 2;
      if (bus.short_epoch !== 1'b1) begin failures++; $display("FAIL short_flag: got %b expected 1", bus.short_epoch); end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL short_idle: got busy %b expected 0", bus.busy); end
      repeat (3) tick();
      checks++;
      if (si_cyc.size() != 0) begin failures++; $display("FAIL short_no_launch: got %0d pulses expected 0", si_cyc.size()); end
      clear_obs();
      pulse_start();
      checks += 3;
      if (bus.short_epoch !== 1'b0) begin failures++; $display("FAIL short_cleared: got %b expected 0", bus.short_epoch); end
      if (bus.overflow !== 1'b0) begin failures++; $display("FAIL overflow_cleared: got %b expected 0", bus.overflow); end
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL restart_busy: got %b expected 1", bus.busy); end
      s = int'($urandom_range(0, 65535));
      push(s);
      tick();
      checks++;
      if (obs_addr.size() != 1 || obs_addr[0] != BASE || obs_data[0] != exp_data(s)) begin
         failures++;
         $display("FAIL restart_first_write: got %0d writes addr %h data %h expected 1 write addr %h data %h",
                  obs_addr.size(), obs_addr.size() > 0 ? obs_addr[0] : -1, obs_data.size() > 0 ? obs_data[0] : -1, BASE, exp_data(s));
      end
   endtask

   task automatic test_restart_in_infer();
      logic [2:0] st;
      clear_obs();
      pulse_start();
      repeat (8) push(int'($urandom_range(0, 65535)));
      repeat (3) tick();
      checks++;
      if (si_cyc.size() != 1) begin failures++; $display("FAIL reload_launch: got %0d pulses expected 1", si_cyc.size()); end
      pulse_start();
      st = 3'((3 + $urandom_range(1, 7)) % 8);
      bus.core_sleep_stage = st;
      bus.core_inference_complete = 1'b1;
      tick();
      bus.core_inference_complete = 1'b0;
      checks += 3;
      if (bus.inference_complete !== 1'b0) begin failures++; $display("FAIL stale_complete_pulse: got %b expected 0", bus.inference_complete); end
      if (bus.inferred_sleep_stage !== 3'd3) begin failures++; $display("FAIL stale_complete_stage: got %0d expected 3", bus.inferred_sleep_stage); end
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL stale_complete_busy: got %b expected 1", bus.busy); end
      bus.start_eeg_load = 1'b1;
      bus.new_sleep_epoch = 1'b1;
      tick();
      bus.start_eeg_load = 1'b0;
      bus.new_sleep_epoch = 1'b0;
      checks += 2;
      if (bus.short_epoch !== 1'b0) begin failures++; $display("FAIL start_beats_epoch_flag: got %b expected 0", bus.short_epoch); end
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL start_beats_epoch_busy: got %b expected 1", bus.busy); end
   endtask

   task automatic test_reset_midload();
      bus.mem_wr_ready = 1'b0;
      repeat (3) push(int'($urandom_range(0, 65535)));
      checks++;
      if (bus.mem_wr_en !== 1'b1) begin failures++; $display("FAIL midload_pending: got %b expected 1", bus.mem_wr_en); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (all_outs() !== '0) begin failures++; $display("FAIL async_reset_outputs: got %h expected 0", all_outs()); end
      #10 rst_n = 1'b1;
      bus.mem_wr_ready = 1'b1;
      repeat (4) begin
         tick();
         checks++;
         if (bus.mem_wr_en !== 1'b0) begin failures++; $display("FAIL post_reset_en: got %b expected 0", bus.mem_wr_en); end
      end
   endtask

   initial begin
      bus.start_eeg_load = 1'b0;
      bus.new_eeg_data = 1'b0;
      bus.eeg = '0;
      bus.new_sleep_epoch = 1'b0;
      bus.mem_wr_ready = 1'b0;
      bus.core_inference_complete = 1'b0;
      bus.core_sleep_stage = 3'd0;
      test_reset();
      test_main();
      test_inference();
      test_overflow();
      test_short_epoch();
      test_restart_in_infer();
      test_reset_midload();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
